// File: rtl/sfixed_add_arbiter.sv
// sfixed_add_arbiter: round-robin shared signed fixed-point adder with a one-deep result register
//   Optional feature: define SFIXED_ADD_ARB_SATURATE_EN to clamp out-of-range sums to max/min (otherwise wrap).
//   Ports: clk, rst (sync, active-high); req_valid/req_ready/req_a/req_b per requester (operands packed, requester i at [i*W_IN +: W_IN]);
//          res_valid/res_ready/res_data/res_id result handshake, res_id names the requester that owns res_data.
module sfixed_add_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IN_LEFT   = 3,
  parameter int IN_RIGHT  = 4,
  parameter int OUT_LEFT  = 3,
  parameter int OUT_RIGHT = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_REQ-1:0]                           req_valid,
  output logic [NUM_REQ-1:0]                           req_ready,
  input  logic [NUM_REQ*(IN_LEFT+IN_RIGHT+1)-1:0]      req_a,
  input  logic [NUM_REQ*(IN_LEFT+IN_RIGHT+1)-1:0]      req_b,
  output logic                                         res_valid,
  input  logic                                         res_ready,
  output logic [OUT_LEFT+OUT_RIGHT:0]                  res_data,
  output logic [$clog2(NUM_REQ)-1:0]                   res_id
);
  localparam int W_IN   = IN_LEFT + IN_RIGHT + 1;
  localparam int W_OUT  = OUT_LEFT + OUT_RIGHT + 1;
  localparam int W_FULL = IN_LEFT + IN_RIGHT + 2;
  localparam int TOP    = IN_RIGHT + OUT_LEFT;
  localparam int LSB    = IN_RIGHT - OUT_RIGHT;
  // the sum is widened far enough that the output slice never runs off its top
  localparam int WX     = (TOP + 1 > W_FULL) ? TOP + 1 : W_FULL;
  localparam int IDW    = $clog2(NUM_REQ);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nx;
  logic [IDW-1:0] ptr, ptr_nx, win;
  logic can_accept, xfer;
  logic [W_IN-1:0] a, b;
  logic [WX-1:0] sum_x;
  logic [W_OUT-1:0] res_nx;
  logic unused_sum;
  // scan offsets from far to near so the nearest valid index at or after ptr wins
  always_comb begin
    win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(ptr) + k) % NUM_REQ]) win = IDW'((int'(ptr) + k) % NUM_REQ);
  end
  assign can_accept = (state == EMPTY) || res_ready;
  assign req_ready  = (!rst && can_accept && |req_valid) ? NUM_REQ'(1) << win : '0;
  assign xfer       = |(req_valid & req_ready);
  assign ptr_nx     = (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  assign a          = req_a[int'(win)*W_IN +: W_IN];
  assign b          = req_b[int'(win)*W_IN +: W_IN];
  assign sum_x      = {{(WX-W_IN){a[W_IN-1]}}, a} + {{(WX-W_IN){b[W_IN-1]}}, b};
  assign unused_sum = ^sum_x;
`ifdef SFIXED_ADD_ARB_SATURATE_EN
  logic [WX-1-TOP:0] hi;
  logic ovf;
  // bits from the output sign upward must all agree or the value does not fit
  assign hi     = sum_x[WX-1:TOP];
  assign ovf    = !((&hi) || !(|hi));
  assign res_nx = ovf ? {sum_x[WX-1], {(W_OUT-1){~sum_x[WX-1]}}} : sum_x[LSB +: W_OUT];
`else
  assign res_nx = sum_x[LSB +: W_OUT];
`endif
  assign res_valid = (state == FULL);
  always_comb state_nx = xfer ? FULL : (state == FULL && res_ready) ? EMPTY : state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      ptr      <= '0;
      res_data <= '0;
      res_id   <= '0;
    end else begin
      state <= state_nx;
      if (xfer) begin
        ptr      <= ptr_nx;
        res_data <= res_nx;
        res_id   <= win;
      end
    end
  end
endmodule

// File: tb/tb_sfixed_add_arbiter.sv
// tb_sfixed_add_arbiter: scoreboard bench for sfixed_add_arbiter with a behavioural arbitration/arithmetic model
module tb_sfixed_add_arbiter;
  localparam int N = 4, IL = 3, IR = 4, OL = 3, OR_ = 4;
  localparam int W_IN = IL + IR + 1, W_OUT = OL + OR_ + 1, IDW = $clog2(N);
  typedef struct packed { logic [IDW-1:0] id; logic [W_OUT-1:0] d; } exp_t;
  logic clk = 0, rst = 1, res_ready = 0, res_valid;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*W_IN-1:0] req_a = '0, req_b = '0;
  logic [W_OUT-1:0] res_data;
  logic [IDW-1:0] res_id;
  exp_t q[$];
  int checks = 0, fails = 0, mptr = 0;
  bit mfull = 0;
  sfixed_add_arbiter #(.NUM_REQ(N), .IN_LEFT(IL), .IN_RIGHT(IR), .OUT_LEFT(OL), .OUT_RIGHT(OR_)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id));
  always #5 clk = ~clk;
  // real-valued sum scaled to output LSBs, floored, then clamped or wrapped
  function automatic logic [W_OUT-1:0] model_sum(input logic [W_IN-1:0] x, input logic [W_IN-1:0] y);
    int s, mx, mn;
    s  = (int'($signed(x)) + int'($signed(y))) >>> (IR - OR_);
    mx = (1 << (W_OUT - 1)) - 1;
    mn = -(1 << (W_OUT - 1));
`ifdef SFIXED_ADD_ARB_SATURATE_EN
    s = (s > mx) ? mx : (s < mn) ? mn : s;
`endif
    return W_OUT'(s);
  endfunction
  function automatic logic [N*W_IN-1:0] rand_bus();
    logic [N*W_IN-1:0] r;
    for (int i = 0; i < N; i++) r[i*W_IN +: W_IN] = W_IN'($urandom);
    return r;
  endfunction
  task automatic step(input logic r, input logic [N-1:0] v, input logic rr,
                      input logic [N*W_IN-1:0] a, input logic [N*W_IN-1:0] b);
    int win;
    logic [N-1:0] exp_rdy;
    @(posedge clk);
    #2;
    rst = r; req_valid = v; res_ready = rr; req_a = a; req_b = b;
    #1;
    win = -1;
    for (int k = 0; k < N; k++)
      if (win < 0 && v[(mptr + k) % N]) win = (mptr + k) % N;
    exp_rdy = (!r && (!mfull || rr) && win >= 0) ? N'(1) << win : '0;
    checks++;
    if (req_ready !== exp_rdy) begin
      fails++;
      $display("FAIL req_ready: got %b expected %b at %0t", req_ready, exp_rdy, $time);
    end
    checks++;
    if (res_valid !== mfull) begin
      fails++;
      $display("FAIL res_valid: got %b expected %b at %0t", res_valid, mfull, $time);
    end
    if (r) begin
      mfull = 0; mptr = 0; q.delete();
    end else if (exp_rdy != '0) begin
      q.push_back('{id: IDW'(win), d: model_sum(a[win*W_IN +: W_IN], b[win*W_IN +: W_IN])});
      mptr = (win + 1) % N;
      mfull = 1;
    end else if (mfull && rr) mfull = 0;
  endtask
  // monitor: every cycle a result is presented it must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      if (q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_result: got id %0d data %h expected none", res_id, res_data);
      end else begin
        checks += 2;
        if (res_data !== q[0].d) begin
          fails++;
          $display("FAIL res_data: got %h expected %h at %0t", res_data, q[0].d, $time);
        end
        if (res_id !== q[0].id) begin
          fails++;
          $display("FAIL res_id: got %0d expected %0d at %0t", res_id, q[0].id, $time);
        end
        if (res_ready) void'(q.pop_front());
      end
    end
  end
  initial begin
    logic [N*W_IN-1:0] ta, tb_;
    repeat (2) @(posedge clk);
    step(1, 4'hF, 1, rand_bus(), rand_bus());
    step(0, 4'h0, 1, rand_bus(), rand_bus());
    repeat (5) step(0, 4'hF, 1, rand_bus(), rand_bus());
    repeat (2) step(0, 4'h0, 1, rand_bus(), rand_bus());
    ta = rand_bus(); tb_ = rand_bus();
    ta[2*W_IN +: W_IN] = 8'h18; tb_[2*W_IN +: W_IN] = 8'h28;
    step(0, 4'b0100, 1, ta, tb_);
    step(0, 4'h0, 1, rand_bus(), rand_bus());
    ta[2*W_IN +: W_IN] = 8'h78; tb_[2*W_IN +: W_IN] = 8'h10;
    step(0, 4'b0100, 1, ta, tb_);
    ta[3*W_IN +: W_IN] = 8'h80; tb_[3*W_IN +: W_IN] = 8'hF0;
    step(0, 4'b1000, 1, ta, tb_);
    ta[0 +: W_IN] = 8'h80; tb_[0 +: W_IN] = 8'h80;
    step(0, 4'b0001, 1, ta, tb_);
    ta[1*W_IN +: W_IN] = 8'h7F; tb_[1*W_IN +: W_IN] = 8'h7F;
    step(0, 4'b0010, 1, ta, tb_);
    step(0, 4'h0, 1, rand_bus(), rand_bus());
    step(0, 4'hF, 1, rand_bus(), rand_bus());
    repeat (3) step(0, 4'hF, 0, rand_bus(), rand_bus());
    repeat (2) step(0, 4'hF, 1, rand_bus(), rand_bus());
    step(0, 4'h0, 1, rand_bus(), rand_bus());
    step(0, 4'b0010, 1, rand_bus(), rand_bus());
    step(1, 4'hF, 0, rand_bus(), rand_bus());
    step(0, 4'b0101, 1, rand_bus(), rand_bus());
    step(0, 4'b0101, 1, rand_bus(), rand_bus());
    repeat (400) step(($urandom_range(0, 49) == 0), N'($urandom), ($urandom_range(0, 3) != 0), rand_bus(), rand_bus());
    repeat (3) step(0, 4'h0, 1, rand_bus(), rand_bus());
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d results outstanding expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
